// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Register file with a per-register busy scoreboard for the
//             multi-cycle MIPS core. A destination is reserved through a
//             valid/ready issue handshake and stays busy until it is
//             written back. Decode uses busy1/busy2 to stall on RAW hazards.
//  Ports    : clk, rst (async, active high)
//             ra1/ra2 -> rd1/rd2, busy1/busy2   read ports (combinational)
//             RegWrite, wa, wd                  writeback port
//             issue_valid, issue_wa -> issue_ready  destination reservation
//             pending                           number of busy registers
//  Options  : REGFILE_BYPASS_EN  when defined, a writeback that targets a
//             read address is forwarded to rdN (and clears busyN) in the
//             same cycle. Undefined by default.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_wa,
  output logic              issue_ready,
  output logic [ADDR_W:0]   pending
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]  r_regs [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [c_DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]    r_pending;

  logic w_zero_wa;
  logic w_zero_iwa;
  logic w_zero_ra1;
  logic w_zero_ra2;
  logic w_wr_en;
  logic w_accept;
  logic w_set;
  logic w_inc;
  logic w_dec;
  logic w_byp1;
  logic w_byp2;

  // Register 0 is special only when ZERO_REG is set.
  assign w_zero_wa  = (ZERO_REG != 0) && (wa == '0);
  assign w_zero_iwa = (ZERO_REG != 0) && (issue_wa == '0);
  assign w_zero_ra1 = (ZERO_REG != 0) && (ra1 == '0);
  assign w_zero_ra2 = (ZERO_REG != 0) && (ra2 == '0);

  assign w_wr_en = RegWrite && !w_zero_wa;

  // A busy destination can be re-reserved in the very cycle its writeback
  // lands, so the control FSM does not lose a cycle on WAW.
  assign issue_ready = !r_busy[issue_wa] || (RegWrite && (wa == issue_wa));
  assign w_accept    = issue_valid && issue_ready;
  assign w_set       = w_accept && !w_zero_iwa;

  // pending tracks the popcount of r_busy incrementally: count only real
  // 0->1 and 1->0 transitions. A writeback and a re-reservation on the same
  // busy register leave that bit at 1, hence no change.
  assign w_inc = w_set && !r_busy[issue_wa];
  assign w_dec = w_wr_en && r_busy[wa] && !(w_set && (wa == issue_wa));

  // Reservation is applied after the writeback, so the newer one wins.
  for (genvar i = 0; i < c_DEPTH; i++) begin : g_busy
    assign w_busy_nxt[i] = (w_set   && (issue_wa == ADDR_W'(i))) ? 1'b1 :
                           (w_wr_en && (wa       == ADDR_W'(i))) ? 1'b0 :
                           r_busy[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= r_pending + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wa] <= wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = w_wr_en && (wa == ra1);
  assign w_byp2 = w_wr_en && (wa == ra2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    rd1   = r_regs[ra1];
    busy1 = r_busy[ra1];
    if (w_byp1) begin
      rd1   = wd;
      busy1 = 1'b0;
    end
    if (w_zero_ra1) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
  end

  always_comb begin
    rd2   = r_regs[ra2];
    busy2 = r_busy[ra2];
    if (w_byp2) begin
      rd2   = wd;
      busy2 = 1'b0;
    end
    if (w_zero_ra2) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
  end

  assign pending = r_pending;

endmodule
`default_nettype wire
